// File: rtl/pcs_pkg.sv
// Shared PCS constants: block geometry, gearbox sequence length and sync headers.
// Imported by the gearbox and its bench.
package pcs_pkg;

   localparam int HEAD_W   = 2;
   localparam int BLOCK_W  = 66;
   localparam int GB_SEQ_N = 33;
   localparam int GB_CNT_W = 6;

   localparam logic [HEAD_W-1:0] SYNC_DATA = 2'b10;
   localparam logic [HEAD_W-1:0] SYNC_CTRL = 2'b01;

endpackage : pcs_pkg

// File: rtl/gearbox_tx_if.sv
// Block-in / word-out bundle of the 66b->64b transmit gearbox.
// Optional debug id lane is present only with GEARBOX_DEBUG_ID_EN.
interface gearbox_tx_if #(
   parameter int DATA_W = 64,
   parameter int HEAD_W = 2
);

   logic [HEAD_W-1:0] head_i;
   logic [DATA_W-1:0] data_i;
   logic              ready_o;
   logic [DATA_W-1:0] data_o;

`ifdef GEARBOX_DEBUG_ID_EN
   logic [63:0] debug_id_i;
   logic [63:0] debug_id_o;

   modport master (
      output head_i, data_i, debug_id_i,
      input  ready_o, data_o, debug_id_o
   );

   modport slave (
      input  head_i, data_i, debug_id_i,
      output ready_o, data_o, debug_id_o
   );
`else
   modport master (
      output head_i, data_i,
      input  ready_o, data_o
   );

   modport slave (
      input  head_i, data_i,
      output ready_o, data_o
   );
`endif

endinterface : gearbox_tx_if

// File: rtl/gearbox_tx.sv
// 66b->64b transmit gearbox: 32 blocks in, 33 words out, one upstream stall per 33 cycles.
// Optional GEARBOX_DEBUG_ID_EN adds a debug id registered alongside data_o.
module gearbox_tx #(
   parameter int DATA_W = 64,
   parameter int HEAD_W = 2
) (
   input logic         clk,
   input logic         nreset,
   gearbox_tx_if.slave bus
);

   import pcs_pkg::*;

   localparam int BW     = DATA_W + HEAD_W;
   localparam int WIDE_W = 2 * DATA_W;
   localparam logic [GB_CNT_W-1:0] FLUSH_CNT = GB_CNT_W'(GB_SEQ_N - 1);

   if (((DATA_W + HEAD_W) * 32 != DATA_W * 33) || (BW != BLOCK_W)) begin : g_param_check
      $error("gearbox_tx: only DATA_W=64, HEAD_W=2 is supported");
   end

   logic [GB_CNT_W-1:0] cnt;
   logic [DATA_W-1:0]   r;
   logic [BW-1:0]       block;
   logic [GB_CNT_W:0]   shamt;
   logic [WIDE_W-1:0]   merged;

   assign block = {bus.data_i, bus.head_i};
   assign shamt = {cnt, 1'b0};

   // Low half is the outgoing word, high half is the new residue (2k+2 bits, rest zero).
   // NOTE: combinational logic must assign every output on every path, or a latch is inferred.
   always_comb begin
      merged = ({{(WIDE_W - BW){1'b0}}, block} << shamt) | {{(WIDE_W - DATA_W){1'b0}}, r};
   end

   assign bus.ready_o = (cnt != FLUSH_CNT);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         cnt        <= '0;
         r          <= '0;
         bus.data_o <= '0;
      end else if (cnt == FLUSH_CNT) begin
         bus.data_o <= r;
         r          <= '0;
         cnt        <= '0;
      end else begin
         bus.data_o <= merged[DATA_W-1:0];
         r          <= merged[WIDE_W-1:DATA_W];
         cnt        <= cnt + GB_CNT_W'(1);
      end
   end

`ifdef GEARBOX_DEBUG_ID_EN
   // Id tracks the accepted block; it holds through the flush cycle.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         bus.debug_id_o <= '0;
      end else if (cnt != FLUSH_CNT) begin
         bus.debug_id_o <= bus.debug_id_i;
      end
   end
`endif

endmodule : gearbox_tx

// File: tb/tb_gearbox_tx.sv
// Scoreboard bench for gearbox_tx: a serial bit-stream model predicts every output word.
// Build with GEARBOX_DEBUG_ID_EN to also score debug_id_o.
module tb_gearbox_tx;

   import pcs_pkg::*;

   localparam int DW = 64;

   typedef struct {
      logic [63:0] word;
      logic        ready;
      logic [63:0] dbg;
   } exp_t;

   logic clk = 1'b0;
   logic nreset;

   always #5 clk = ~clk;

   gearbox_tx_if #(.DATA_W(DW), .HEAD_W(HEAD_W)) bus ();

   gearbox_tx #(.DATA_W(DW), .HEAD_W(HEAD_W)) dut (
      .clk    (clk),
      .nreset (nreset),
      .bus    (bus.slave)
   );

   exp_t        exp_q[$];
   bit          bitq[$];
   int          model_cnt = 0;
   logic [63:0] exp_dbg   = '0;
   logic [63:0] next_id   = 64'd1;
   int          checks    = 0;
   int          errors    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Serial model: blocks go into the transmit bit stream header-first, LSB-first;
   // each output word is simply the next 64 bits of that stream.
   task automatic model_edge(input logic [1:0] head, input logic [63:0] data,
                             input logic [63:0] id);
      logic [65:0] b;
      logic [63:0] w;
      if (model_cnt != 32) begin
         b = {data, head};
         for (int i = 0; i < 66; i++) bitq.push_back(b[i]);
         model_cnt++;
         exp_dbg = id;
      end else begin
         model_cnt = 0;
      end
      if (bitq.size() < 64) begin
         checks++;
         errors++;
         $display("FAIL model_stream: got %0d bits expected at least 64", bitq.size());
      end else begin
         for (int i = 0; i < 64; i++) w[i] = bitq.pop_front();
         exp_q.push_back('{w, (model_cnt != 32), exp_dbg});
      end
   endtask

   task automatic drive_cycle(input logic [1:0] head, input logic [63:0] data);
      bus.head_i = head;
      bus.data_i = data;
`ifdef GEARBOX_DEBUG_ID_EN
      bus.debug_id_i = next_id;
`endif
      @(posedge clk);
      model_edge(head, data, next_id);
      next_id++;
      #1;
   endtask

   task automatic model_reset();
      model_cnt = 0;
      exp_dbg   = '0;
      bitq.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data_o"}, bus.data_o, 64'h0);
      check({tag, "_ready_o"}, {63'h0, bus.ready_o}, 64'h1);
`ifdef GEARBOX_DEBUG_ID_EN
      check({tag, "_debug_id_o"}, bus.debug_id_o, 64'h0);
`endif
   endtask

   // Monitor: the DUT presents one word every clock out of reset; compare at the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_data_o", bus.data_o, e.word);
            check("sb_ready_o", {63'h0, bus.ready_o}, {63'h0, e.ready});
`ifdef GEARBOX_DEBUG_ID_EN
            check("sb_debug_id_o", bus.debug_id_o, e.dbg);
`endif
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] idx;

      // Reset with arbitrary inputs
      nreset     = 1'b0;
      bus.head_i = 2'b11;
      bus.data_i = 64'hA5A5_5A5A_F0F0_0F0F;
`ifdef GEARBOX_DEBUG_ID_EN
      bus.debug_id_i = 64'h1234;
`endif
      #12;
      check_reset_outputs("rst_init");
      @(negedge clk);
      #1;
      check_reset_outputs("rst_hold");
      nreset = 1'b1;

      // Constant data block: one '1' at stream offset 66m+1
      for (int n = 1; n <= 33; n++) begin
         drive_cycle(SYNC_DATA, 64'h0);
         if (n == 1)  check("const_w1", bus.data_o, 64'h0000_0000_0000_0002);
         if (n == 2)  check("const_w2", bus.data_o, 64'h0000_0000_0000_0008);
         if (n == 32) check("const_w32", bus.data_o, 64'h8000_0000_0000_0000);
         if (n == 32) check("const_ready32", {63'h0, bus.ready_o}, 64'h0);
         if (n == 33) check("const_w33", bus.data_o, 64'h0);
         if (n == 33) check("const_ready33", {63'h0, bus.ready_o}, 64'h1);
`ifdef GEARBOX_DEBUG_ID_EN
         if (n == 1)  check("dbg_first", bus.debug_id_o, 64'd1);
         if (n == 33) check("dbg_flush_hold", bus.debug_id_o, 64'd32);
`endif
      end

      // Incrementing payload with alternating headers; junk driven during every stall
      idx = 64'd0;
      for (int n = 0; n < 1000; n++) begin
         if (model_cnt == 32) begin
            drive_cycle(2'b11, ~idx);
         end else begin
            drive_cycle(idx[0] ? SYNC_DATA : SYNC_CTRL, idx);
            idx++;
         end
      end

      // Mid-sequence reset at cnt = 17
      for (int n = 0; n < 40 && model_cnt != 17; n++) begin
         drive_cycle(SYNC_CTRL, 64'h0123_4567_89AB_CDEF ^ idx);
         idx++;
      end
      check("pre_rst_cnt17", 64'(model_cnt), 64'd17);
      @(negedge clk);
      #1;
      nreset = 1'b0;
      model_reset();
      #1;
      check_reset_outputs("rst_mid_async");
      for (int n = 0; n < 3; n++) begin
         bus.head_i = 2'b10;
         bus.data_i = 64'hFFFF_0000_FFFF_0000;
         @(posedge clk);
         #1;
         check_reset_outputs("rst_mid_hold");
      end
      @(negedge clk);
      #1;
      nreset = 1'b1;

      drive_cycle(SYNC_CTRL, 64'hDEAD_BEEF_0123_4567);
      check("post_rst_w0", bus.data_o, 64'h7AB6_FBBC_048D_159D);
      for (int n = 0; n < 40; n++) begin
         drive_cycle(n[0] ? SYNC_DATA : SYNC_CTRL, 64'hC0DE_0000_0000_0000 | 64'(n));
      end

      repeat (2) @(negedge clk);
      #1;
      check("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_gearbox_tx
